// File: rtl/paralelo_serial_param_if.sv
// Parallel-word handshake and serial-output bundle for paralelo_serial_param.
// The master side (producer/observer) drives valid_in/data_in and watches the
// serial stream; the slave side is the serialiser itself.
interface paralelo_serial_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;
  logic             data_out;
  logic             frame_sync;
  logic             sending_data;
  logic [CNTW-1:0]  fifo_count;

  modport master (
    output valid_in,
    output data_in,
    input  ready_out,
    input  data_out,
    input  frame_sync,
    input  sending_data,
    input  fifo_count
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output ready_out,
    output data_out,
    output frame_sync,
    output sending_data,
    output fifo_count
  );
endinterface

// File: rtl/paralelo_serial_param.sv
// Parallel-to-serial converter with a small input FIFO.
// Words are queued through a valid/ready handshake and serialised one bit per
// clk_32f cycle in back-to-back frames of WIDTH bits. When nothing is queued
// at a frame boundary the IDLE_WORD pattern is sent instead, so the line never
// goes quiet. frame_sync marks the first bit of each frame and sending_data
// tells the receiver whether the frame carries real data.
module paralelo_serial_param #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
  parameter bit               LSB_FIRST = 1'b0
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  paralelo_serial_param_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(WIDTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNTW-1:0]  count_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] word_r;
  logic             data_out_r;
  logic             frame_sync_r;
  logic             sending_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic             ready_s;
  logic             push_s;
  logic             load_s;
  logic             fifo_empty_s;
  logic             pop_s;
  logic             last_bit_s;
  logic [CW-1:0]    bit_idx_s;
  logic [WIDTH-1:0] sel_word_s;
  logic             next_bit_s;

  // Handshake, frame-boundary and FIFO-pop decode, all from pre-edge state so
  // a word pushed on a frame-load edge waits for the following frame.
  always_comb begin
    ready_s      = 1'b0;
    push_s       = 1'b0;
    load_s       = 1'b0;
    fifo_empty_s = 1'b1;
    pop_s        = 1'b0;
    last_bit_s   = 1'b0;
    if (reset) begin
      ready_s = (count_r < CNTW'(DEPTH));
    end else begin
      ready_s = 1'b0;
    end
    push_s       = bus.valid_in && ready_s;
    load_s       = (bit_cnt_r == CW'(0));
    fifo_empty_s = (count_r == CNTW'(0));
    if (reset && load_s && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    last_bit_s = (bit_cnt_r == CW'(WIDTH - 1));
  end

  // Bit-position to word-index mapping; the frame position equals bit_cnt_r.
  always_comb begin
    bit_idx_s = '0;
    if (LSB_FIRST) begin
      bit_idx_s = bit_cnt_r;
    end else begin
      bit_idx_s = CW'(WIDTH - 1) - bit_cnt_r;
    end
  end

  // Word feeding the serial output: on a frame load it is the FIFO head or the
  // idle pattern, otherwise the word latched at the start of this frame.
  always_comb begin
    sel_word_s = word_r;
    if (load_s) begin
      if (fifo_empty_s) begin
        sel_word_s = IDLE_WORD;
      end else begin
        sel_word_s = mem_r[rd_ptr_r];
      end
    end else begin
      sel_word_s = word_r;
    end
    next_bit_s = sel_word_s[bit_idx_s];
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Frame bit counter: 0..WIDTH-1, wrapping, restarted by reset so the first
  // released edge is a frame load.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      bit_cnt_r <= CW'(0);
    end else if (last_bit_s) begin
      bit_cnt_r <= CW'(0);
    end else begin
      bit_cnt_r <= bit_cnt_r + CW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_32f) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.data_in;
    end
  end

  // FIFO pointers, wrapping naturally because DEPTH is a power of two.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      count_r <= CNTW'(0);
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serial output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      word_r       <= '0;
      data_out_r   <= 1'b0;
      frame_sync_r <= 1'b0;
      sending_r    <= 1'b0;
    end else begin
      data_out_r   <= next_bit_s;
      frame_sync_r <= load_s;
      if (load_s) begin
        word_r    <= sel_word_s;
        sending_r <= !fifo_empty_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ready_out    = ready_s;
  assign bus.data_out     = data_out_r;
  assign bus.frame_sync   = frame_sync_r;
  assign bus.sending_data = sending_r;
  assign bus.fifo_count   = count_r;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Scoreboard bench for paralelo_serial_param. Two instances share stimulus:
// u_dut0 is MSB-first, u_dut1 is LSB-first. A frame-level reference model
// (a queue of pending words plus a frame position) predicts which word each
// frame carries; a separate monitor rebuilds words from the serial stream
// and compares them with the predictions.
module tb_paralelo_serial_param;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hBC;

  typedef struct packed {
    logic       is_data;
    logic [7:0] word;
  } frame_t;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       valid_s = 1'b0;
  logic [7:0] data_s  = 8'h00;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  paralelo_serial_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

  assign bus0.valid_in = valid_s;
  assign bus0.data_in  = data_s;
  assign bus1.valid_in = valid_s;
  assign bus1.data_in  = data_s;

  paralelo_serial_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_WORD(IDLE), .LSB_FIRST(1'b0))
    u_dut0 (.clk_32f(clk_32f), .reset(reset), .bus(bus0));
  paralelo_serial_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_WORD(IDLE), .LSB_FIRST(1'b1))
    u_dut1 (.clk_32f(clk_32f), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  frame_t     expq[$];
  int         pos = 0;
  bit         exp_fs = 1'b0;
  bit         last_rst_low = 1'b1;
  int         accepted_total = 0;
  int         flushed_total = 0;

  // Monitor state
  frame_t     cur[2];
  bit         active[2];
  int         nbits[2];
  logic [7:0] accw[2];
  int         aborted[2];
  int         data_seen[2];
  bit         saw_full = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: at each frame boundary the oldest queued word (or the
  // idle pattern) becomes the next expected frame; acceptance uses the
  // queue size before the edge.
  always @(posedge clk_32f) begin
    if (!reset) begin
      flushed_total += mq.size();
      mq.delete();
      expq.delete();
      pos          = 0;
      exp_fs       = 1'b0;
      last_rst_low = 1'b1;
    end else begin
      bit acc;
      acc    = valid_s && (mq.size() < DEPTH);
      exp_fs = (pos == 0);
      if (pos == 0) begin
        if (mq.size() > 0) expq.push_back({1'b1, mq.pop_front()});
        else               expq.push_back({1'b0, IDLE});
      end
      if (acc) begin
        mq.push_back(data_s);
        accepted_total++;
      end
      pos          = (pos + 1) % WIDTH;
      last_rst_low = 1'b0;
    end
  end

  // Monitor: sample away from the active edge, rebuild frames, compare.
  always @(negedge clk_32f) begin
    logic [1:0] dout, fs, sd, rdy;
    logic [2:0] cnt [2];
    frame_t     popped;
    bit         have_pop;
    dout = {bus1.data_out, bus0.data_out};
    fs   = {bus1.frame_sync, bus0.frame_sync};
    sd   = {bus1.sending_data, bus0.sending_data};
    rdy  = {bus1.ready_out, bus0.ready_out};
    cnt[0] = bus0.fifo_count;
    cnt[1] = bus1.fifo_count;
    popped   = '0;
    have_pop = 1'b0;
    if (!last_rst_low && (fs != 2'b00)) begin
      if (expq.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        popped   = expq.pop_front();
        have_pop = 1'b1;
      end
    end
    if (cnt[0] == 3'(DEPTH) && !rdy[0]) saw_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("ready_out", int'(rdy[i]), int'(reset && (mq.size() < DEPTH)));
      check("fifo_count", int'(cnt[i]), mq.size());
      if (last_rst_low) begin
        check("rst_data_out", int'(dout[i]), 0);
        check("rst_frame_sync", int'(fs[i]), 0);
        check("rst_sending", int'(sd[i]), 0);
        if (active[i] && cur[i].is_data && nbits[i] < WIDTH) aborted[i]++;
        active[i] = 1'b0;
      end else begin
        check("frame_sync", int'(fs[i]), int'(exp_fs));
        if (fs[i] && have_pop) begin
          if (active[i]) check("frame_length", nbits[i], WIDTH);
          cur[i]    = popped;
          active[i] = 1'b1;
          nbits[i]  = 0;
          accw[i]   = 8'h00;
        end
        if (active[i]) begin
          if (nbits[i] >= WIDTH) begin
            check("frame_gap", nbits[i], WIDTH - 1);
            active[i] = 1'b0;
          end else begin
            check("sending_data", int'(sd[i]), int'(cur[i].is_data));
            if (i == 0) accw[i] = {accw[i][6:0], dout[i]};
            else        accw[i][nbits[i]] = dout[i];
            nbits[i]++;
            if (nbits[i] == WIDTH) begin
              check(i == 0 ? "word_msb" : "word_lsb", int'(accw[i]), int'(cur[i].word));
              if (cur[i].is_data) data_seen[i]++;
            end
          end
        end
      end
    end
  end

  // Apply inputs 2 time units after a rising edge; they take effect next edge.
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    @(posedge clk_32f);
    #2;
    reset   = r;
    valid_s = v;
    data_s  = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0; nbits[i] = 0; accw[i] = 8'h00; cur[i] = '0;
      aborted[i] = 0; data_seen[i] = 0;
    end

    // Reset held, then free-running idle frames.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h55);
    idle(20);

    // Three consecutive pushes.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hEE);
    step(1'b1, 1'b1, 8'hDD);
    idle(40);

    // Six words with valid held: only the accepted ones may appear.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 8'h10 + 8'(k));
    idle(60);

    // Gapped valid, data changing on the idle cycles.
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 8'hCC);
    step(1'b1, 1'b1, 8'hCC);
    step(1'b1, 1'b0, 8'hAA);
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 8'h01);
    idle(50);

    // Pushes landing at every frame phase.
    for (int ph = 0; ph < WIDTH; ph++) begin
      idle(ph);
      step(1'b1, 1'b1, 8'(8'h40 + ph));
      idle(WIDTH * 2);
    end

    // Reset in the middle of a data frame.
    step(1'b1, 1'b1, 8'hBB);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step(1'b1, 1'b0, 8'h00);
      if (bus0.frame_sync && bus0.sending_data) found = 1'b1;
    end
    check("bb_frame_started", int'(found), 1);
    idle(2);
    step(1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b0, 8'h00);
    idle(30);

    // Randomised traffic with occasional resets.
    for (int seg = 0; seg < 3; seg++) begin
      int prob;
      prob = (seg == 0) ? 30 : (seg == 1) ? 70 : 100;
      for (int k = 0; k < 300; k++) begin
        step(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < prob), 8'($urandom));
      end
    end

    // Drain and account for every accepted word.
    idle(60);
    check("saw_full", int'(saw_full), 1);
    check("queue_drained", mq.size(), 0);
    for (int i = 0; i < 2; i++) begin
      check("words_delivered", data_seen[i], accepted_total - flushed_total - aborted[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
